// File: rtl/dmem_access.sv
// dmem_access: data-memory access unit that sits after the retire stage.
// Memory operations from retire are buffered in a small FIFO. They are then
// issued one at a time on a valid/ready memory port. The unit aligns store
// data to byte lanes, builds the write strobes, and sign- or zero-extends
// load data. A misaligned access is dropped and reported instead of issued.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   dmem_*_in, rob_addr_in,  request from retire (store wins if both enables set)
//   dest_in
//   busy_out                 FIFO full; retire must hold off
//   mem_req_*, mem_we,       request channel to data memory (word address,
//   mem_addr, mem_wdata,     lane-replicated data, byte strobes)
//   mem_wstrb
//   mem_rsp_valid, mem_rdata load response from data memory
//   ld_*                     completed load, one-cycle pulse on ld_valid
//   misaligned_*             dropped access, one-cycle pulse on misaligned_out
module dmem_access #(
    parameter int unsigned REQ_FIFO_DEPTH = 4,
    parameter int unsigned ROB_ADDR_W     = 6,
    parameter int unsigned PRF_ADDR_W     = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dmem_wr_en_in,
    input  logic                  dmem_rd_en_in,
    input  logic [31:0]           dmem_addr_in,
    input  logic [31:0]           dmem_data_in,
    input  logic [2:0]            dmem_funct3_in,
    input  logic [ROB_ADDR_W-1:0] rob_addr_in,
    input  logic [PRF_ADDR_W-1:0] dest_in,
    output logic                  busy_out,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [31:0]           mem_rdata,
    output logic                  ld_valid,
    output logic [ROB_ADDR_W-1:0] ld_rob_addr,
    output logic [PRF_ADDR_W-1:0] ld_dest,
    output logic [31:0]           ld_value,
    output logic                  misaligned_out,
    output logic [ROB_ADDR_W-1:0] misaligned_rob_addr
);

    localparam int unsigned PTR_W = $clog2(REQ_FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                  we;
        logic [31:0]           addr;
        logic [31:0]           data;
        logic [2:0]            f3;
        logic [ROB_ADDR_W-1:0] rob;
        logic [PRF_ADDR_W-1:0] dest;
    } req_t;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitRsp
    } state_e;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    req_t             r_fifo [REQ_FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    req_t w_push_entry;
    req_t w_head;

    assign w_full   = (r_count == CNT_W'(REQ_FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_push   = (dmem_wr_en_in | dmem_rd_en_in) & ~w_full;
    assign busy_out = w_full;
    assign w_head   = r_fifo[r_rd_ptr];

    // A store takes priority when retire raises both enables.
    assign w_push_entry = '{
        we:   dmem_wr_en_in,
        addr: dmem_addr_in,
        data: dmem_data_in,
        f3:   dmem_funct3_in,
        rob:  rob_addr_in,
        dest: dest_in
    };

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= w_push_entry;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head decode: alignment check and store lane placement
    // funct3[1:0] selects the size; 011/110/111 fall into the word case.
    // ------------------------------------------------------------------
    logic        w_head_aligned;
    logic [31:0] w_head_wdata;
    logic [3:0]  w_head_wstrb;
    logic [1:0]  w_head_off;

    assign w_head_off = w_head.addr[1:0];

    always_comb begin
        w_head_aligned = 1'b1;
        w_head_wdata   = w_head.data;
        w_head_wstrb   = 4'b1111;
        case (w_head.f3[1:0])
            2'b00: begin
                w_head_wdata = {4{w_head.data[7:0]}};
                w_head_wstrb = 4'b0001 << w_head_off;
            end
            2'b01: begin
                w_head_aligned = ~w_head_off[0];
                w_head_wdata   = {2{w_head.data[15:0]}};
                w_head_wstrb   = 4'b0011 << w_head_off;
            end
            default: begin
                w_head_aligned = (w_head_off == 2'b00);
            end
        endcase
        if (!w_head.we) begin
            w_head_wdata = '0;
            w_head_wstrb = 4'b0000;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_e r_state;
    state_e w_state_next;
    logic   w_latch;
    logic   w_mis;
    logic   w_ld_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_latch      = 1'b0;
        w_mis        = 1'b0;
        w_ld_done    = 1'b0;
        case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_head_aligned) begin
                        w_latch      = 1'b1;
                        w_state_next = StReq;
                    end else begin
                        w_mis = 1'b1;
                    end
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    w_state_next = mem_we ? StIdle : StWaitRsp;
                end
            end
            StWaitRsp: begin
                if (mem_rsp_valid) begin
                    w_ld_done    = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    assign mem_req_valid = (r_state == StReq);

    // ------------------------------------------------------------------
    // Request register and load context
    // ------------------------------------------------------------------
    logic                  r_we;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic [1:0]            r_ld_off;
    logic [2:0]            r_ld_f3;
    logic [ROB_ADDR_W-1:0] r_req_rob;
    logic [PRF_ADDR_W-1:0] r_req_dest;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_ld_off   <= '0;
            r_ld_f3    <= '0;
            r_req_rob  <= '0;
            r_req_dest <= '0;
        end else if (w_latch) begin
            r_we       <= w_head.we;
            r_addr     <= {w_head.addr[31:2], 2'b00};
            r_wdata    <= w_head_wdata;
            r_wstrb    <= w_head_wstrb;
            r_ld_off   <= w_head_off;
            r_ld_f3    <= w_head.f3;
            r_req_rob  <= w_head.rob;
            r_req_dest <= w_head.dest;
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wstrb = r_wstrb;

    // ------------------------------------------------------------------
    // Load extraction and completion outputs
    // Halfword loads are only issued with off[0]=0, so off[1] picks the half.
    // ------------------------------------------------------------------
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_ext;

    assign w_ld_byte = mem_rdata[{r_ld_off, 3'b000} +: 8];
    assign w_ld_half = mem_rdata[{r_ld_off[1], 4'b0000} +: 16];

    always_comb begin
        w_ld_ext = mem_rdata;
        case (r_ld_f3)
            3'b000:  w_ld_ext = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b100:  w_ld_ext = {24'h0, w_ld_byte};
            3'b001:  w_ld_ext = {{16{w_ld_half[15]}}, w_ld_half};
            3'b101:  w_ld_ext = {16'h0, w_ld_half};
            default: w_ld_ext = mem_rdata;
        endcase
    end

    logic                  r_ld_valid;
    logic [ROB_ADDR_W-1:0] r_ld_rob;
    logic [PRF_ADDR_W-1:0] r_ld_dest;
    logic [31:0]           r_ld_value;
    logic                  r_mis;
    logic [ROB_ADDR_W-1:0] r_mis_rob;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_valid <= 1'b0;
            r_ld_rob   <= '0;
            r_ld_dest  <= '0;
            r_ld_value <= '0;
            r_mis      <= 1'b0;
            r_mis_rob  <= '0;
        end else begin
            r_ld_valid <= w_ld_done;
            r_mis      <= w_mis;
            if (w_ld_done) begin
                r_ld_rob   <= r_req_rob;
                r_ld_dest  <= r_req_dest;
                r_ld_value <= w_ld_ext;
            end
            if (w_mis) begin
                r_mis_rob <= w_head.rob;
            end
        end
    end

    assign ld_valid            = r_ld_valid;
    assign ld_rob_addr         = r_ld_rob;
    assign ld_dest             = r_ld_dest;
    assign ld_value            = r_ld_value;
    assign misaligned_out      = r_mis;
    assign misaligned_rob_addr = r_mis_rob;

endmodule

// File: tb/tb_dmem_access.sv
// Self-checking bench for dmem_access: directed cases with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model (queue of pending ops, one outstanding op).
module tb_dmem_access;

    localparam int DEPTH = 4;
    localparam int ROBW  = 6;
    localparam int PRFW  = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            wr_en, rd_en;
    logic [31:0]     addr_in, data_in;
    logic [2:0]      f3_in;
    logic [ROBW-1:0] rob_in;
    logic [PRFW-1:0] dest_in;
    logic            busy_out;
    logic            mem_req_valid, mem_req_ready, mem_we;
    logic [31:0]     mem_addr, mem_wdata;
    logic [3:0]      mem_wstrb;
    logic            mem_rsp_valid;
    logic [31:0]     mem_rdata;
    logic            ld_valid;
    logic [ROBW-1:0] ld_rob_addr;
    logic [PRFW-1:0] ld_dest;
    logic [31:0]     ld_value;
    logic            misaligned_out;
    logic [ROBW-1:0] misaligned_rob_addr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_access #(
        .REQ_FIFO_DEPTH(DEPTH),
        .ROB_ADDR_W    (ROBW),
        .PRF_ADDR_W    (PRFW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .dmem_wr_en_in      (wr_en),
        .dmem_rd_en_in      (rd_en),
        .dmem_addr_in       (addr_in),
        .dmem_data_in       (data_in),
        .dmem_funct3_in     (f3_in),
        .rob_addr_in        (rob_in),
        .dest_in            (dest_in),
        .busy_out           (busy_out),
        .mem_req_valid      (mem_req_valid),
        .mem_req_ready      (mem_req_ready),
        .mem_we             (mem_we),
        .mem_addr           (mem_addr),
        .mem_wdata          (mem_wdata),
        .mem_wstrb          (mem_wstrb),
        .mem_rsp_valid      (mem_rsp_valid),
        .mem_rdata          (mem_rdata),
        .ld_valid           (ld_valid),
        .ld_rob_addr        (ld_rob_addr),
        .ld_dest            (ld_dest),
        .ld_value           (ld_value),
        .misaligned_out     (misaligned_out),
        .misaligned_rob_addr(misaligned_rob_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        logic            we;
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [2:0]      f3;
        logic [ROBW-1:0] rob;
        logic [PRFW-1:0] dest;
    } op_t;

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit is_aligned(input op_t o);
        return (o.addr % size_of(o.f3)) == 0;
    endfunction

    function automatic logic [31:0] exp_wdata(input op_t o);
        case (size_of(o.f3))
            1:       return {4{o.data[7:0]}};
            2:       return {2{o.data[15:0]}};
            default: return o.data;
        endcase
    endfunction

    function automatic logic [3:0] exp_wstrb(input op_t o);
        int n;
        n = size_of(o.f3);
        if (!o.we) return 4'b0000;
        return 4'(((1 << n) - 1) << o.addr[1:0]);
    endfunction

    function automatic logic [31:0] exp_load(input op_t o, input logic [31:0] rd);
        longint v;
        int     bits;
        bits = 8 * size_of(o.f3);
        if (bits == 32) return rd;
        v = longint'((rd >> (8 * o.addr[1:0])) & ((32'd1 << bits) - 1));
        // f3[2]=0 selects sign extension for byte/half loads
        if (!o.f3[2] && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
        return 32'(v);
    endfunction

    op_t             mq[$];
    op_t             cur;
    op_t             hd;
    op_t             nw;
    int              phase = 0;  // 0 free, 1 request pending, 2 awaiting data
    bit              e_ld  = 0;
    bit              e_mis = 0;
    bit              n_ld, n_mis, do_pop, do_push;
    logic [31:0]     e_val;
    logic [ROBW-1:0] e_ld_rob, e_mis_rob;
    logic [PRFW-1:0] e_ld_dest;

    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            phase = 0;
            e_ld  = 0;
            e_mis = 0;
            chk("rst_busy", 32'(busy_out), 32'd0);
            chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
            chk("rst_ld_valid", 32'(ld_valid), 32'd0);
            chk("rst_misaligned", 32'(misaligned_out), 32'd0);
        end else begin
            chk("busy", 32'(busy_out), 32'(mq.size() == DEPTH));
            chk("req_valid", 32'(mem_req_valid), 32'(phase == 1));
            if (phase == 1) begin
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                chk("mem_addr", mem_addr, cur.addr & 32'hFFFF_FFFC);
                chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb(cur)));
                if (cur.we) chk("mem_wdata", mem_wdata, exp_wdata(cur));
            end
            chk("ld_valid", 32'(ld_valid), 32'(e_ld));
            if (e_ld) begin
                chk("ld_value", ld_value, e_val);
                chk("ld_rob", 32'(ld_rob_addr), 32'(e_ld_rob));
                chk("ld_dest", 32'(ld_dest), 32'(e_ld_dest));
            end
            chk("misaligned", 32'(misaligned_out), 32'(e_mis));
            if (e_mis) chk("mis_rob", 32'(misaligned_rob_addr), 32'(e_mis_rob));

            // advance model across the coming clock edge
            n_ld    = 0;
            n_mis   = 0;
            do_pop  = (phase == 0) && (mq.size() > 0);
            do_push = (wr_en || rd_en) && (mq.size() < DEPTH);
            if (phase == 1 && mem_req_ready) begin
                phase = cur.we ? 0 : 2;
            end else if (phase == 2 && mem_rsp_valid) begin
                n_ld      = 1;
                e_val     = exp_load(cur, mem_rdata);
                e_ld_rob  = cur.rob;
                e_ld_dest = cur.dest;
                phase     = 0;
            end
            if (do_pop) begin
                hd = mq.pop_front();
                if (is_aligned(hd)) begin
                    cur   = hd;
                    phase = 1;
                end else begin
                    n_mis     = 1;
                    e_mis_rob = hd.rob;
                end
            end
            if (do_push) begin
                nw.we   = wr_en;
                nw.addr = addr_in;
                nw.data = data_in;
                nw.f3   = f3_in;
                nw.rob  = rob_in;
                nw.dest = dest_in;
                mq.push_back(nw);
            end
            e_ld  = n_ld;
            e_mis = n_mis;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic push_op(input logic we, input logic rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] f3,
                           input logic [ROBW-1:0] rob, input logic [PRFW-1:0] dst);
        @(posedge clk);
        #1;
        wr_en   = we;
        rd_en   = rd;
        addr_in = a;
        data_in = d;
        f3_in   = f3;
        rob_in  = rob;
        dest_in = dst;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst           = 1'b0;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        addr_in       = '0;
        data_in       = '0;
        f3_in         = '0;
        rob_in        = '0;
        dest_in       = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;

        repeat (2) @(negedge clk);
        chk("reset_mem_addr", mem_addr, 32'h0);
        chk("reset_ld_value", ld_value, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;

        // SB to byte 3: top lane only, data replicated
        mem_req_ready = 1'b1;
        push_op(1'b1, 1'b0, 32'h0000_1003, 32'h0000_00A5, 3'b000, 6'd5, 7'd0);
        @(negedge clk);
        @(negedge clk);
        chk("sb_valid", 32'(mem_req_valid), 32'd1);
        chk("sb_addr", mem_addr, 32'h0000_1000);
        chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
        chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        @(negedge clk);
        chk("sb_one_cycle", 32'(mem_req_valid), 32'd0);

        // LB / LBU at offset 1
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h0000_8000;
        push_op(1'b0, 1'b1, 32'h0000_2001, 32'h0, 3'b000, 6'd9, 7'd17);
        repeat (4) @(negedge clk);
        chk("lb_valid", 32'(ld_valid), 32'd1);
        chk("lb_value", ld_value, 32'hFFFF_FF80);
        chk("lb_rob", 32'(ld_rob_addr), 32'd9);
        chk("lb_dest", 32'(ld_dest), 32'd17);
        @(negedge clk);
        chk("lb_pulse", 32'(ld_valid), 32'd0);
        push_op(1'b0, 1'b1, 32'h0000_2001, 32'h0, 3'b100, 6'd10, 7'd18);
        repeat (4) @(negedge clk);
        chk("lbu_value", ld_value, 32'h0000_0080);

        // LH at offset 2, then a misaligned LW
        mem_rdata = 32'h8001_0000;
        push_op(1'b0, 1'b1, 32'h0000_3002, 32'h0, 3'b001, 6'd3, 7'd4);
        repeat (4) @(negedge clk);
        chk("lh_valid", 32'(ld_valid), 32'd1);
        chk("lh_value", ld_value, 32'hFFFF_8001);
        push_op(1'b0, 1'b1, 32'h0000_3001, 32'h0, 3'b010, 6'd12, 7'd1);
        @(negedge clk);
        @(negedge clk);
        chk("lw_mis", 32'(misaligned_out), 32'd1);
        chk("lw_mis_rob", 32'(misaligned_rob_addr), 32'd12);
        chk("lw_no_req", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        chk("lw_mis_pulse", 32'(misaligned_out), 32'd0);
        mem_rsp_valid = 1'b0;

        // Backpressure: memory stalled, retire keeps pushing stores
        mem_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            wr_en   = 1'b1;
            addr_in = 32'h100 + 32'(4 * i);
            data_in = 32'(i);
            f3_in   = 3'b010;
            rob_in  = ROBW'(i);
        end
        @(posedge clk);
        #1 wr_en = 1'b0;
        @(negedge clk);
        chk("bp_busy", 32'(busy_out), 32'd1);
        chk("bp_first_addr", mem_addr, 32'h0000_0100);
        @(posedge clk);
        #1 mem_req_ready = 1'b1;
        repeat (15) @(negedge clk);
        chk("bp_drained", 32'(busy_out), 32'd0);

        // Both enables: a single store
        push_op(1'b1, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 3'b010, 6'd7, 7'd2);
        @(negedge clk);
        @(negedge clk);
        chk("both_we", 32'(mem_we), 32'd1);
        chk("both_wstrb", 32'(mem_wstrb), 32'hF);
        chk("both_wdata", mem_wdata, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);

        // Reset while awaiting load data
        mem_rdata = 32'h0000_1234;
        push_op(1'b0, 1'b1, 32'h0000_5000, 32'h0, 3'b010, 6'd21, 7'd33);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", 32'(mem_req_valid), 32'd0);
        chk("mid_rst_we", 32'(mem_we), 32'd0);
        chk("mid_rst_addr", mem_addr, 32'h0);
        chk("mid_rst_wdata", mem_wdata, 32'h0);
        chk("mid_rst_wstrb", 32'(mem_wstrb), 32'h0);
        chk("mid_rst_ld_rob", 32'(ld_rob_addr), 32'd0);
        chk("mid_rst_ld_dest", 32'(ld_dest), 32'd0);
        chk("mid_rst_ld_value", ld_value, 32'h0);
        chk("mid_rst_mis_rob", 32'(misaligned_rob_addr), 32'd0);
        chk("mid_rst_busy", 32'(busy_out), 32'd0);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_rsp", 32'(ld_valid), 32'd0);
        end
        @(posedge clk);
        #1 mem_rsp_valid = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            wr_en         = 1'b0;
            rd_en         = 1'b0;
            if ($urandom_range(0, 9) < 4) begin
                wr_en = 1'($urandom_range(0, 2) == 0);
                rd_en = 1'($urandom_range(0, 3) != 0);
                if (!wr_en && !rd_en) rd_en = 1'b1;
            end
            addr_in       = $urandom;
            data_in       = $urandom;
            f3_in         = 3'($urandom_range(0, 7));
            rob_in        = ROBW'($urandom);
            dest_in       = PRFW'($urandom);
            mem_req_ready = 1'($urandom_range(0, 2) != 0);
            mem_rsp_valid = 1'($urandom_range(0, 1));
            mem_rdata     = $urandom;
        end

        // Quiet drain
        @(posedge clk);
        #1;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b1;
        repeat (40) @(negedge clk);
        chk("final_idle_req", 32'(mem_req_valid), 32'd0);
        chk("final_idle_busy", 32'(busy_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
